// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_pkg
//  Description : Shared types and constants for the SPI command controller:
//                FSM state encoding, command byte layout, reset defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    // Command FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DROP = 3'd4
    } state_e;

    // Command byte: bit 7 selects read (1) or write (0)
    localparam int         CMD_RD_BIT  = 7;
    // Default power-on value of reg[0]
    localparam logic [7:0] RST_VAL_DEF = 8'h30;

    // A command is well formed when every bit between the address field and
    // the read/write flag is zero.
    function automatic logic cmd_rsv_clear(input logic [7:0] cmd, input int aw);
        return ((cmd[6:0] >> aw) == 7'd0);
    endfunction

endpackage : spi_cmd_pkg
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_bank
//  Description : NREG x 8-bit register bank with one SPI write port, one
//                combinational read port and local increment/decrement of
//                reg[0]. An SPI write to reg[0] wins over a coincident key
//                request; the key op is parked one deep and applied next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_cmd_pkg::*;
#(
    parameter int         NREG    = 8,
    parameter int         AW      = 3,
    parameter logic [7:0] RST_VAL = RST_VAL_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          key_inc_i,
    input  logic          key_dec_i,
    output logic [7:0]    rd_data_o,
    output logic [7:0]    disp_data_o
);

    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];
    logic       pend_q;
    logic       pend_d;
    logic       pend_inc_q;
    logic       pend_inc_d;

    logic       w_inc_only;
    logic       w_dec_only;
    logic       w_wr0;

    // Simultaneous inc and dec cancel out and are treated as no request
    assign w_inc_only = key_inc_i & ~key_dec_i;
    assign w_dec_only = key_dec_i & ~key_inc_i;
    assign w_wr0      = wr_en_i && (wr_addr_i == '0);

    // Next-state of the bank: SPI write first, then reg[0] key arbitration
    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        pend_inc_d = pend_inc_q;
        if (wr_en_i) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
        if (w_wr0) begin
            // SPI owns reg[0] this cycle; park the key op if the slot is free
            if (!pend_q && (w_inc_only || w_dec_only)) begin
                pend_d     = 1'b1;
                pend_inc_d = w_inc_only;
            end
        end else if (pend_q) begin
            // Parked op is applied; any new key request this cycle is dropped
            regs_d[0] = pend_inc_q ? (regs_q[0] + 8'd1) : (regs_q[0] - 8'd1);
            pend_d    = 1'b0;
        end else if (w_inc_only) begin
            regs_d[0] = regs_q[0] + 8'd1;
        end else if (w_dec_only) begin
            regs_d[0] = regs_q[0] - 8'd1;
        end
    end

    // Register bank and pending-op storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 0) ? RST_VAL : 8'h00;
            end
            pend_q     <= 1'b0;
            pend_inc_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_inc_q <= pend_inc_d;
        end
    end

    assign rd_data_o   = regs_q[rd_addr_i];
    assign disp_data_o = regs_q[0];

endmodule : spi_reg_bank
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_ctrl
//  Description : Byte-level command decoder behind an SPI slave. Decodes a
//                command byte (read/write + start address), streams writes
//                into the register bank or streams reads back to the slave
//                with auto-incrementing address, and counts frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int         NREG    = 8,
    parameter int         AW      = 3,
    parameter logic [7:0] RST_VAL = RST_VAL_DEF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] disp_data,
    output logic       cmd_err,
    output logic [7:0] frame_cnt
);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic          armed_q;
    logic [7:0]    tx_data_q;
    logic          tx_load_q;
    logic          cmd_err_q;
    logic [7:0]    frame_cnt_q;

    logic          w_cmd_ok;
    logic          w_cmd_rd;
    logic          w_wr_en;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;

    assign w_cmd_ok = cmd_rsv_clear(rx_data, AW);
    assign w_cmd_rd = rx_data[CMD_RD_BIT];
    assign w_wr_en  = (state_q == S_WR) && rx_valid;

    // Read address: the command's start address while decoding, otherwise the
    // next sequential address (addr_q wraps naturally since NREG = 2**AW)
    assign w_rd_addr = (state_q == S_CMD) ? rx_data[AW-1:0] : (addr_q + AW'(1));

    spi_reg_bank #(
        .NREG    (NREG),
        .AW      (AW),
        .RST_VAL (RST_VAL)
    ) u_reg_bank (
        .clk_i       (sys_clk),
        .rst_i       (rst),
        .wr_en_i     (w_wr_en),
        .wr_addr_i   (addr_q),
        .wr_data_i   (rx_data),
        .rd_addr_i   (w_rd_addr),
        .key_inc_i   (key_inc),
        .key_dec_i   (key_dec),
        .rd_data_o   (w_rd_data),
        .disp_data_o (disp_data)
    );

    // Command FSM, address counter and all registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            armed_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            tx_load_q <= 1'b0;
            // A frame may only start once ncs has been seen high after reset
            if (ncs) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    tx_data_q <= 8'h00;
                    if (!ncs && armed_q) begin
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        if (w_cmd_ok) begin
                            addr_q    <= rx_data[AW-1:0];
                            cmd_err_q <= 1'b0;
                            if (w_cmd_rd) begin
                                state_q   <= S_RD;
                                tx_data_q <= w_rd_data;
                                tx_load_q <= 1'b1;
                            end else begin
                                state_q <= S_WR;
                            end
                        end else begin
                            cmd_err_q <= 1'b1;
                            state_q   <= S_DROP;
                        end
                    end
                end
                S_WR: begin
                    if (rx_valid) begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                S_RD: begin
                    if (rx_valid) begin
                        addr_q    <= w_rd_addr;
                        tx_data_q <= w_rd_data;
                        tx_load_q <= 1'b1;
                    end
                end
                S_DROP: begin
                    tx_data_q <= 8'h00;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Frame end overrides the per-state transition but keeps the
            // side effects of a byte that arrived in the same cycle
            if ((state_q != S_IDLE) && ncs) begin
                state_q     <= S_IDLE;
                tx_data_q   <= 8'h00;
                tx_load_q   <= 1'b0;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign cmd_err   = cmd_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule : spi_cmd_ctrl
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cmd_ctrl
//  Description : Self-checking bench for spi_cmd_ctrl. A transaction-level
//                model (register array, frame counter, error flag) predicts
//                every read byte, flag and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ncs;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       key_inc;
    logic       key_dec;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] disp_data;
    logic       cmd_err;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    // Model: frame phase 0=command, 1=write, 2=read, 3=drop, 4=not in frame
    logic [7:0] m_regs [8];
    int         m_addr;
    int         m_st;
    logic       m_err;
    logic [7:0] m_fc;

    spi_cmd_ctrl dut (
        .sys_clk   (clk),
        .rst       (rst),
        .ncs       (ncs),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .disp_data (disp_data),
        .cmd_err   (cmd_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_regs[0] = 8'h30;
        m_addr = 0;
        m_st   = 4;
        m_err  = 1'b0;
        m_fc   = 8'h00;
    endtask

    task automatic start_frame();
        ncs = 1'b0;
        @(negedge clk);
        m_st = 0;
    endtask

    // Present one byte for a single cycle; optionally raise ncs with it.
    task automatic send_byte(input logic [7:0] b, input bit coinc);
        logic       exp_ld;
        logic [7:0] exp_d;
        rx_valid = 1'b1;
        rx_data  = b;
        if (coinc) ncs = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        exp_ld = 1'b0;
        exp_d  = 8'h00;
        case (m_st)
            0: begin
                if ((b & 8'h78) != 8'h00) begin
                    m_err = 1'b1;
                    m_st  = 3;
                end else begin
                    m_err  = 1'b0;
                    m_addr = b & 8'h07;
                    if (b >= 8'h80) begin
                        m_st   = 2;
                        exp_ld = 1'b1;
                        exp_d  = m_regs[m_addr];
                    end else begin
                        m_st = 1;
                    end
                end
            end
            1: begin
                m_regs[m_addr] = b;
                m_addr = (m_addr + 1) % 8;
            end
            2: begin
                m_addr = (m_addr + 1) % 8;
                exp_ld = 1'b1;
                exp_d  = m_regs[m_addr];
            end
            default: ;
        endcase
        if (coinc) begin
            exp_ld = 1'b0;
            exp_d  = 8'h00;
            if (m_st != 4) m_fc = m_fc + 8'd1;
            m_st = 4;
        end
        chk("tx_load", {7'd0, tx_load}, {7'd0, exp_ld});
        chk("tx_data", tx_data, exp_d);
    endtask

    task automatic end_frame();
        if (!ncs) begin
            ncs = 1'b1;
            @(negedge clk);
            if (m_st != 4) m_fc = m_fc + 8'd1;
        end
        m_st = 4;
        chk("frame_cnt", frame_cnt, m_fc);
        chk("cmd_err", {7'd0, cmd_err}, {7'd0, m_err});
        chk("disp_data", disp_data, m_regs[0]);
        chk("idle_tx_data", tx_data, 8'h00);
        chk("idle_tx_load", {7'd0, tx_load}, 8'h00);
        @(negedge clk);
    endtask

    task automatic key_pulse(input logic inc, input logic dec);
        key_inc = inc;
        key_dec = dec;
        @(negedge clk);
        key_inc = 1'b0;
        key_dec = 1'b0;
        if (inc && !dec) m_regs[0] = m_regs[0] + 8'd1;
        if (dec && !inc) m_regs[0] = m_regs[0] - 8'd1;
        chk("key_disp", disp_data, m_regs[0]);
    endtask

    initial begin
        logic [7:0] cmd;
        int         n;
        bit         coinc_last;

        rst = 1'b1; ncs = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        key_inc = 1'b0; key_dec = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_load", {7'd0, tx_load}, 8'h00);
        chk("rst_disp", disp_data, 8'h30);
        chk("rst_cmd_err", {7'd0, cmd_err}, 8'h00);
        chk("rst_frame_cnt", frame_cnt, 8'h00);

        // Write frame: reg[2]=AA, reg[3]=BB, then read them back
        start_frame(); send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0); end_frame();
        start_frame(); send_byte(8'h82, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); end_frame();

        // Read wrap: reg[7]=11, reg[0]=30 -> 11, 30, 00
        start_frame(); send_byte(8'h07, 0); send_byte(8'h11, 0); end_frame();
        start_frame(); send_byte(8'h87, 0); send_byte(8'h5A, 0); send_byte(8'hA5, 0); end_frame();

        // Bad command, then a valid one clears the flag
        start_frame(); send_byte(8'h40, 0); send_byte(8'h55, 0); end_frame();
        start_frame(); send_byte(8'h01, 0); end_frame();

        // Last byte coincides with ncs rising: byte still written
        start_frame(); send_byte(8'h05, 0); send_byte(8'h66, 0); send_byte(8'h77, 1); end_frame();
        start_frame(); send_byte(8'h85, 0); send_byte(8'h00, 0); end_frame();

        // Collision: SPI write FF to reg[0] with key_inc; key_dec next cycle is dropped
        start_frame(); send_byte(8'h00, 0);
        rx_valid = 1'b1; rx_data = 8'hFF; key_inc = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; key_inc = 1'b0; key_dec = 1'b1;
        chk("coll_written", disp_data, 8'hFF);
        @(negedge clk);
        key_dec = 1'b0;
        chk("coll_applied", disp_data, 8'h00);
        @(negedge clk);
        chk("coll_dropped", disp_data, 8'h00);
        m_regs[0] = 8'h00; m_addr = 1;
        end_frame();

        // Key wrap and simultaneous inc+dec
        key_pulse(1'b0, 1'b1);
        key_pulse(1'b1, 1'b1);
        key_pulse(1'b1, 1'b0);
        key_pulse(1'b1, 1'b0);

        // Reset mid-frame with ncs held low: remaining bytes ignored
        start_frame(); send_byte(8'h04, 0); send_byte(8'h12, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_byte(8'h84, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
        end_frame();
        start_frame(); send_byte(8'h84, 0); send_byte(8'h00, 0); end_frame();

        // Randomized frames
        for (int k = 0; k < 30; k++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd = cmd | 8'h08;
            else                           cmd = cmd & 8'h87;
            n = $urandom_range(0, 4);
            coinc_last = ($urandom_range(0, 3) == 0);
            start_frame();
            send_byte(cmd, coinc_last && (n == 0));
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(8'($urandom), coinc_last && (j == n - 1));
            end
            end_frame();
        end

        // Full read-back of the bank
        start_frame();
        send_byte(8'h80, 0);
        for (int j = 0; j < 8; j++) send_byte(8'($urandom), 0);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_spi_cmd_ctrl
`default_nettype wire

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning number of 8-bit registers (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 3, meaning register address width, log2(NREG).
REQ-003 SHALL have parameter RST_VAL, default 8'h30, meaning reset value of reg[0]; all other registers reset to 8'h00.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ncs  in  1  chip select, already synchronised to sys_clk, low = frame active.
REQ-007 rx_valid  in  1  one-cycle pulse: a complete byte was received from the SPI slave.
REQ-008 rx_data  in  8  received byte, valid with rx_valid.
REQ-009 key_inc  in  1  one-cycle pulse: local request to increment reg[0].
REQ-010 key_dec  in  1  one-cycle pulse: local request to decrement reg[0].
REQ-011 tx_data  out  8  byte the SPI slave shifts out next.
REQ-012 tx_load  out  1  one-cycle pulse: tx_data is updated.
REQ-013 disp_data  out  8  current reg[0], for the LCD display.
REQ-014 cmd_err  out  1  sticky flag: a malformed command was received; cleared by the next valid command byte.
REQ-015 frame_cnt  out  8  count of completed frames, wraps from 255 to 0.

Function
REQ-016 FSM states SHALL be S_IDLE, S_CMD, S_WR, S_RD and S_DROP.
REQ-017 S_IDLE: on ncs low SHALL go to S_CMD; otherwise remain.
REQ-018 Command byte format: bit7 = 1 read, 0 write; bits[AW-1:0] = start address; all other bits SHALL be 0.
REQ-019 S_CMD, rx_valid, reserved bits zero: SHALL latch addr, clear cmd_err, and go to S_RD (read) or S_WR (write).
REQ-020 S_CMD, rx_valid, reserved bits nonzero: SHALL set cmd_err and go to S_DROP.
REQ-021 S_DROP SHALL ignore all bytes until ncs is high.
REQ-022 S_WR, rx_valid: SHALL write rx_data to reg[addr], then addr = addr+1 mod NREG.
REQ-023 Entering S_RD: SHALL drive tx_data = reg[addr] and pulse tx_load on the cycle after the command rx_valid.
REQ-024 S_RD, rx_valid: SHALL set addr+1 mod NREG, then drive tx_data = reg[new addr] and pulse tx_load one cycle after rx_valid.
REQ-025 Outside S_RD, tx_data SHALL be 8'h00 and tx_load SHALL be low.
REQ-026 In any non-idle state, ncs high SHALL return the FSM to S_IDLE and increment frame_cnt once.
REQ-027 If rx_valid and ncs rise coincide, the byte SHALL be processed first, then the FSM SHALL go to S_IDLE.
REQ-028 key_inc alone SHALL set reg[0] to reg[0]+1 mod 256; key_dec alone SHALL set it to reg[0]-1 mod 256.
REQ-029 key_inc and key_dec asserted together SHALL be ignored.
REQ-030 If an SPI write to reg[0] coincides with a key request, the SPI write SHALL win; the key op SHALL be held in a one-deep pending register and applied to the written value on the next cycle.
REQ-031 A new key request arriving while an op is pending SHALL be dropped.
REQ-032 disp_data SHALL equal reg[0] with zero added latency from the register.

Reset
REQ-033 In reset: state = S_IDLE, reg[0] = RST_VAL, other registers = 0, addr = 0, pending cleared, tx_data = 0, tx_load = 0, cmd_err = 0, frame_cnt = 0.
REQ-034 If ncs is low when reset releases, the FSM SHALL stay in S_IDLE until ncs has been high for at least one cycle, so a partial frame is never decoded.

Structure
REQ-035 State encodings, the command bit positions and RST_VAL default SHALL live in shared package spi_cmd_pkg.
REQ-036 The register bank with its key-arbitration logic SHALL be one sub-module, spi_reg_bank; the FSM and address counter SHALL stay in spi_cmd_ctrl.

Verification
REQ-037 Write frame: ncs low, bytes 8'h02, 8'hAA, 8'hBB, ncs high -> reg[2] = AA, reg[3] = BB, frame_cnt = 1.
REQ-038 Read wrap: reg[7] = 8'h11, reg[0] = 8'h30; frame 8'h87, dummy, dummy -> tx_data sequence 11, 30, 00, each with a tx_load one cycle after its rx_valid.
REQ-039 Bad command: byte 8'h40 then 8'h55 -> cmd_err = 1, no register changes; next frame with 8'h01 -> cmd_err = 0.
REQ-040 Collision: SPI write of 8'hFF to reg[0] in the same cycle as key_inc -> reg[0] = FF, then 00 one cycle later.
REQ-041 Key wrap: reg[0] = 00, key_dec -> FF; key_inc together with key_dec -> unchanged.
REQ-042 Reset mid-frame: rst during S_WR with ncs held low -> remaining bytes ignored; the next full frame decodes normally.
